// File: rtl/security_arm_sequencer_if.sv
// rtl/security_arm_sequencer_if.sv - keypad/sensor inputs and status outputs of the arm sequencer
interface security_arm_sequencer_if;
    logic       arm_req;
    logic       disarm_req;
    logic       motion_sensor;
    logic       door_sensor;
    logic       manual_override;
    logic [2:0] state;
    logic       armed;
    logic       warn_beep;
    logic       siren;
    logic       alarm_latched;
    logic       arm_fail;
    logic [7:0] alarm_count;

    modport master (
        output arm_req, disarm_req, motion_sensor, door_sensor, manual_override,
        input  state, armed, warn_beep, siren, alarm_latched, arm_fail, alarm_count
    );

    modport slave (
        input  arm_req, disarm_req, motion_sensor, door_sensor, manual_override,
        output state, armed, warn_beep, siren, alarm_latched, arm_fail, alarm_count
    );
endinterface

// File: rtl/security_arm_sequencer.sv
// rtl/security_arm_sequencer.sv - exit/entry delay arming FSM with timed siren; SECURITY_ALARM_LOG_EN enables alarm_count
module security_arm_sequencer #(
    parameter int EXIT_DELAY  = 8,
    parameter int ENTRY_DELAY = 4,
    parameter int ALARM_TIME  = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    security_arm_sequencer_if.slave        bus
);
    localparam int MAX_ED    = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
    localparam int MAX_DELAY = (MAX_ED > ALARM_TIME) ? MAX_ED : ALARM_TIME;
    localparam int TW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_DELAY - 1);
    localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_DELAY - 1);
    localparam logic [TW-1:0] ALARM_LOAD = TW'(ALARM_TIME - 1);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    state_t        st;
    logic [TW-1:0] timer;
    logic          alarm_latched_q;
    logic          arm_fail_q;

    // Timed states load DELAY-1 on entry and leave on the edge that sees zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st              <= S_DISARMED;
            timer           <= '0;
            alarm_latched_q <= 1'b0;
            arm_fail_q      <= 1'b0;
        end else begin
            arm_fail_q <= 1'b0;
            if (bus.manual_override) begin
                st              <= S_DISARMED;
                timer           <= '0;
                alarm_latched_q <= 1'b0;
            end else begin
                case (st)
                    S_DISARMED: begin
                        if (!bus.disarm_req && bus.arm_req) begin
                            if (bus.door_sensor) begin
                                arm_fail_q <= 1'b1;
                            end else begin
                                st    <= S_EXIT;
                                timer <= EXIT_LOAD;
                            end
                        end
                    end
                    S_EXIT: begin
                        if (bus.disarm_req) begin
                            st              <= S_DISARMED;
                            timer           <= '0;
                            alarm_latched_q <= 1'b0;
                        end else if (timer == '0) begin
                            st <= S_ARMED;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    S_ARMED: begin
                        if (bus.disarm_req) begin
                            st              <= S_DISARMED;
                            timer           <= '0;
                            alarm_latched_q <= 1'b0;
                        end else if (bus.motion_sensor) begin
                            st              <= S_ALARM;
                            timer           <= ALARM_LOAD;
                            alarm_latched_q <= 1'b1;
                        end else if (bus.door_sensor) begin
                            st    <= S_ENTRY;
                            timer <= ENTRY_LOAD;
                        end
                    end
                    S_ENTRY: begin
                        if (bus.disarm_req) begin
                            st              <= S_DISARMED;
                            timer           <= '0;
                            alarm_latched_q <= 1'b0;
                        end else if (timer == '0) begin
                            st              <= S_ALARM;
                            timer           <= ALARM_LOAD;
                            alarm_latched_q <= 1'b1;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    S_ALARM: begin
                        if (bus.disarm_req) begin
                            st              <= S_DISARMED;
                            timer           <= '0;
                            alarm_latched_q <= 1'b0;
                        end else if (timer == '0) begin
                            st <= S_ARMED;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    default: begin
                        st              <= S_DISARMED;
                        timer           <= '0;
                        alarm_latched_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.state         = st;
    assign bus.armed         = (st == S_ARMED) || (st == S_ENTRY) || (st == S_ALARM);
    assign bus.warn_beep     = (st == S_EXIT) || (st == S_ENTRY);
    assign bus.siren         = (st == S_ALARM);
    assign bus.alarm_latched = alarm_latched_q;
    assign bus.arm_fail      = arm_fail_q;

`ifdef SECURITY_ALARM_LOG_EN
    logic       enter_alarm;
    logic [7:0] alarm_count_q;

    // Mirrors the two FSM paths into ALARM, after override/disarm priority.
    assign enter_alarm = !bus.manual_override && !bus.disarm_req &&
                         (((st == S_ARMED) && bus.motion_sensor) ||
                          ((st == S_ENTRY) && (timer == '0)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            alarm_count_q <= 8'd0;
        end else if (enter_alarm && (alarm_count_q != 8'hFF)) begin
            alarm_count_q <= alarm_count_q + 8'd1;
        end
    end

    assign bus.alarm_count = alarm_count_q;
`else
    assign bus.alarm_count = 8'd0;
`endif
endmodule

// File: doc/security_arm_sequencer.md
Name: security_arm_sequencer

Overview:
- Arming/alarm state machine that sequences the security_alarm function of the smart home controller.
- Adds exit delay, entry delay, a timed siren with auto re-arm, a latched alarm memory and manual-override disarm.
- Sits between the raw sensors / keypad decode and the siren / status outputs of the home automation top level.
- All delays are counted in clk cycles; the top level feeds a prescaled enable domain if seconds are needed.

Parameters:
- EXIT_DELAY, 8: cycles spent in EXIT before entering ARMED. Must be >= 1.
- ENTRY_DELAY, 4: cycles spent in ENTRY before entering ALARM. Must be >= 1.
- ALARM_TIME, 6: cycles the siren sounds before auto re-arm. Must be >= 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-low reset (0 = reset).
- arm_req, input, 1: single-cycle arm request from keypad decode.
- disarm_req, input, 1: single-cycle valid-code disarm request.
- motion_sensor, input, 1: interior motion, level.
- door_sensor, input, 1: entry door open, level.
- manual_override, input, 1: force disarm, level.
- state, output, 3: current state encoding.
- armed, output, 1: system armed.
- warn_beep, output, 1: exit/entry warning tone.
- siren, output, 1: siren drive.
- alarm_latched, output, 1: an alarm occurred since the last disarm.
- arm_fail, output, 1: one-cycle pulse when arming is refused.
- alarm_count, output, 8: number of alarm events (see Optional Feature).

Behaviour:
- Single clock domain; all registers update on the rising edge of clk.
- rst=0 at an edge gives: state=DISARMED, timer=0, alarm_latched=0, arm_fail=0, alarm_count=0. All outputs are 0 on the cycle after reset.
- State encoding: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4. Codes 5-7 are illegal and go to DISARMED on the next edge.
- Down-counter width is $clog2(max(EXIT_DELAY, ENTRY_DELAY, ALARM_TIME)). The counter is loaded with DELAY-1 on state entry, so each timed state lasts exactly DELAY cycles.
- Per-edge priority: rst > manual_override > disarm_req > arm_req > sensor events > timer expiry.
- manual_override=1 forces DISARMED from any state, on every cycle it is held.
- DISARMED:
  - arm_req & !door_sensor -> EXIT.
  - arm_req & door_sensor -> stay in DISARMED and pulse arm_fail for exactly one cycle (registered, the cycle after the request).
- EXIT:
  - Sensors are ignored.
  - disarm_req -> DISARMED.
  - Timer==0 -> ARMED.
  - arm_req is ignored and does not restart the timer.
- ARMED:
  - motion_sensor -> ALARM (immediate).
  - door_sensor alone -> ENTRY.
  - Motion and door in the same cycle -> ALARM.
  - disarm_req -> DISARMED.
- ENTRY:
  - disarm_req -> DISARMED, including on the expiry cycle.
  - Timer==0 -> ALARM.
  - Motion during ENTRY does not shorten the delay.
- ALARM:
  - disarm_req -> DISARMED.
  - Timer==0 -> ARMED (auto re-arm, siren stops).
  - alarm_latched stays at 1.
  - Sensors are re-evaluated only after returning to ARMED.
- Output decode from the registered state (zero added latency):
  - armed=1 in ARMED, ENTRY and ALARM.
  - warn_beep=1 in EXIT and ENTRY.
  - siren=1 in ALARM.
- alarm_latched: set on any edge entering ALARM; cleared on any edge entering DISARMED.
- Reset asserted mid-operation (for example in ALARM) takes effect at that edge, with no siren tail.

Optional Feature:
- Macro: SECURITY_ALARM_LOG_EN.
- Defined: alarm_count increments by 1 on each edge entering ALARM and saturates at 255. Only rst clears it; disarm does not.
- Undefined: no counter logic; alarm_count is tied to 8'd0.

Test Plan:
- Reset and disarmed state:
  - Stimulus: hold rst=0 for 2 cycles with all inputs 1, then release with all inputs 0.
  - Required response: state=0, armed=0, siren=0, alarm_latched=0.
- Normal arm sequence:
  - Stimulus: arm_req pulse with door_sensor=0.
  - Required response: warn_beep=1 for exactly 8 cycles, then state=2 and armed=1.
- Refused arm:
  - Stimulus: arm_req with door_sensor=1.
  - Required response: one arm_fail pulse, state stays 0.
- Entry delay with disarm:
  - Stimulus: in ARMED, door_sensor=1, then disarm_req on the 4th ENTRY cycle.
  - Required response: state=0, siren never 1, alarm_latched=0.
- Motion alarm and auto re-arm:
  - Stimulus: in ARMED, motion_sensor=1 for 1 cycle.
  - Required response: siren=1 for exactly 6 cycles, then state=2 with alarm_latched=1; alarm_count=1 when SECURITY_ALARM_LOG_EN is defined.
- Override and simultaneous events:
  - Stimulus: in ALARM, manual_override=1 together with disarm_req.
  - Required response: DISARMED next edge, alarm_latched=0.
  - Stimulus: in ARMED, door_sensor and motion_sensor in the same cycle.
  - Required response: ALARM (state=4).
